// File: rtl/node_info_pkg.sv
// Shared packet-type codes and role-state encoding for node_info_ctrl and the packet decoder.
package node_info_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_TS   = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;
    localparam logic [2:0] PKT_SOS  = 3'b110;

    typedef enum logic [1:0] {
        ROLE_UNCL   = 2'd0,
        ROLE_MEMBER = 2'd1,
        ROLE_CH     = 2'd2
    } role_state_e;

endpackage

// File: rtl/node_info_ctrl_slot_timer.sv
// One-shot TDMA slot countdown: fires one cycle after the count reaches zero,
// then idles until reloaded. Abort kills the countdown and any pending pulse.
module slot_timer #(
    parameter int unsigned WORD_W = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load,
    input  logic [WORD_W-1:0] value,
    input  logic              abort,
    output logic              fire
);

    logic [WORD_W-1:0] cnt_q;
    logic              active_q;
    logic              fire_q;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            cnt_q    <= '0;
            active_q <= 1'b0;
            fire_q   <= 1'b0;
        end else begin
            fire_q <= 1'b0;
            if (abort) begin
                active_q <= 1'b0;
            end else if (load) begin
                cnt_q    <= value;
                active_q <= 1'b1;
            end else if (active_q) begin
                if (cnt_q == '0) begin
                    fire_q   <= 1'b1;
                    active_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign fire = fire_q;

endmodule

// File: rtl/node_info_ctrl.sv
// Per-node state holder for EER-RL clustering: sink distance, threshold, Q-value, slot,
// role FSM and heartbeat lock. Define NODE_INFO_HB_TIMEOUT_EN to build the lock timeout.
module node_info_ctrl
    import node_info_pkg::*;
#(
    parameter int unsigned       WORD_W     = 16,
    parameter logic [WORD_W-1:0] NODE_ID    = 16'h000C,
    parameter int unsigned       HB_TIMEOUT = 1024,
    parameter int unsigned       LOWE_FILT  = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              en,
    input  logic [2:0]        pkt_type,
    input  logic [WORD_W-1:0] dest_id,
    input  logic [WORD_W-1:0] hops,
    input  logic [WORD_W-1:0] timeslot,
    input  logic [WORD_W-1:0] e_threshold,
    input  logic [WORD_W-1:0] energy,
    input  logic [WORD_W-1:0] q_value_in,
    output logic [WORD_W-1:0] my_node_id,
    output logic [WORD_W-1:0] hops_from_sink,
    output logic [WORD_W-1:0] my_q_value,
    output logic [WORD_W-1:0] e_thresh,
    output logic [WORD_W-1:0] my_timeslot,
    output logic              role,
    output logic              hb_locked,
    output logic              low_e,
    output logic              recluster_req,
    output logic              slot_fire
);

    localparam int unsigned LC_W = $clog2(LOWE_FILT + 1);

    role_state_e       state_q;
    logic [WORD_W-1:0] hops_q, eth_q, q_q, ts_q;
    logic              role_q, hb_locked_q, low_e_q, recl_q;
    logic [LC_W-1:0]   low_cnt_q, low_cnt_d;

    logic is_hb, is_che, is_ts, is_data, is_sos, dest_me, hb_acc, expire;
    logic slot_load, slot_abort;

    assign is_hb   = en && (pkt_type == PKT_HB);
    assign is_che  = en && (pkt_type == PKT_CHE);
    assign is_ts   = en && (pkt_type == PKT_TS);
    assign is_data = en && (pkt_type == PKT_DATA);
    assign is_sos  = en && (pkt_type == PKT_SOS);
    assign dest_me = (dest_id == NODE_ID);
    assign hb_acc  = is_hb && !hb_locked_q;

`ifdef NODE_INFO_HB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(HB_TIMEOUT);

    logic [TO_W-1:0] to_cnt_q;

    assign expire = hb_locked_q && (to_cnt_q == TO_W'(HB_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!nrst) begin
            to_cnt_q <= '0;
        end else if (!hb_locked_q || is_data || expire) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q     <= ROLE_UNCL;
            role_q      <= 1'b0;
            hops_q      <= '1;
            eth_q       <= '0;
            q_q         <= '0;
            ts_q        <= '0;
            hb_locked_q <= 1'b0;
            recl_q      <= 1'b0;
        end else begin
            q_q <= q_value_in;

            if (hb_acc) begin
                hops_q      <= hops;
                eth_q       <= e_threshold;
                hb_locked_q <= 1'b1;
                recl_q      <= 1'b0;
            end else if (is_data || expire) begin
                hb_locked_q <= 1'b0;
            end

            if (is_sos) begin
                recl_q <= 1'b1;
            end

            if (hb_acc) begin
                state_q <= ROLE_UNCL;
                role_q  <= 1'b0;
            end else begin
                case (state_q)
                    ROLE_UNCL, ROLE_MEMBER: begin
                        if (is_che && dest_me) begin
                            state_q <= ROLE_CH;
                            role_q  <= 1'b1;
                        end else if (is_ts && dest_me) begin
                            state_q <= ROLE_MEMBER;
                            ts_q    <= timeslot;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Energy comparison uses the latched threshold, so a threshold of 0 can never trip it.
    always_comb begin
        low_cnt_d = '0;
        if (energy < eth_q) begin
            low_cnt_d = (low_cnt_q == LC_W'(LOWE_FILT)) ? low_cnt_q : low_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            low_cnt_q <= '0;
            low_e_q   <= 1'b0;
        end else begin
            low_cnt_q <= low_cnt_d;
            low_e_q   <= (low_cnt_d == LC_W'(LOWE_FILT));
        end
    end

    assign slot_load  = is_data && (state_q == ROLE_MEMBER);
    assign slot_abort = (state_q == ROLE_MEMBER) && (hb_acc || (is_che && dest_me));

    slot_timer #(
        .WORD_W(WORD_W)
    ) u_slot_timer (
        .clk  (clk),
        .nrst (nrst),
        .load (slot_load),
        .value(ts_q),
        .abort(slot_abort),
        .fire (slot_fire)
    );

    assign my_node_id     = NODE_ID;
    assign hops_from_sink = hops_q;
    assign my_q_value     = q_q;
    assign e_thresh       = eth_q;
    assign my_timeslot    = ts_q;
    assign role           = role_q;
    assign hb_locked      = hb_locked_q;
    assign low_e          = low_e_q;
    assign recluster_req  = recl_q;

endmodule

// File: tb/tb_node_info_ctrl.sv
// Directed plus randomized bench for node_info_ctrl against a timestamp-based reference model.
module tb_node_info_ctrl;
    import node_info_pkg::*;

    localparam int unsigned W   = 16;
    localparam logic [15:0] NID = 16'h000C;
    localparam int unsigned T   = 8;
    localparam int unsigned LF  = 4;
`ifdef NODE_INFO_HB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          nrst, en;
    logic [2:0]    pkt_type;
    logic [W-1:0]  dest_id, hops, timeslot, e_threshold, energy, q_value_in;
    logic [W-1:0]  my_node_id, hops_from_sink, my_q_value, e_thresh, my_timeslot;
    logic          role, hb_locked, low_e, recluster_req, slot_fire;

    always #5 clk = ~clk;

    node_info_ctrl #(
        .WORD_W    (W),
        .NODE_ID   (NID),
        .HB_TIMEOUT(T),
        .LOWE_FILT (LF)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .en            (en),
        .pkt_type      (pkt_type),
        .dest_id       (dest_id),
        .hops          (hops),
        .timeslot      (timeslot),
        .e_threshold   (e_threshold),
        .energy        (energy),
        .q_value_in    (q_value_in),
        .my_node_id    (my_node_id),
        .hops_from_sink(hops_from_sink),
        .my_q_value    (my_q_value),
        .e_thresh      (e_thresh),
        .my_timeslot   (my_timeslot),
        .role          (role),
        .hb_locked     (hb_locked),
        .low_e         (low_e),
        .recluster_req (recluster_req),
        .slot_fire     (slot_fire)
    );

    int passed = 0;
    int total  = 0;

    // Reference model: role as a name-like code (0 unclustered, 1 member, 2 head),
    // lock expiry and slot pulse tracked as absolute edge timestamps.
    longint      ncyc = 0;
    longint      m_lock_at = 0;
    longint      m_fire_at = -1;
    int          m_run = 0;
    int          m_role = 0;
    logic [15:0] m_hops = '1, m_eth = '0, m_q = '0, m_ts = '0;
    bit          m_locked = 0, m_recl = 0, e_low = 0, e_fire = 0;

    task automatic model_edge();
        bit hb_ok, data, expired, me;
        int new_role;
        ncyc++;
        if (!nrst) begin
            m_role = 0; m_hops = '1; m_eth = '0; m_q = '0; m_ts = '0;
            m_locked = 0; m_recl = 0; m_run = 0; m_fire_at = -1;
            e_low = 0; e_fire = 0;
            return;
        end
        m_run   = (energy < m_eth) ? ((m_run >= LF) ? LF : m_run + 1) : 0;
        e_low   = (m_run >= LF);
        e_fire  = 0;
        me      = (dest_id == NID);
        data    = en && (pkt_type == PKT_DATA);
        expired = TO_EN && m_locked && (ncyc - m_lock_at == T);
        hb_ok   = en && (pkt_type == PKT_HB) && !m_locked;

        new_role = m_role;
        if (hb_ok) new_role = 0;
        else if (en && pkt_type == PKT_CHE && me && m_role != 2) new_role = 2;
        else if (en && pkt_type == PKT_TS && me && m_role != 2) begin
            new_role = 1;
            m_ts = timeslot;
        end

        if (m_role == 1 && new_role != 1) m_fire_at = -1;
        else if (data && m_role == 1) m_fire_at = ncyc + longint'(m_ts) + 1;
        else if (m_fire_at == ncyc) begin
            e_fire = 1;
            m_fire_at = -1;
        end
        m_role = new_role;

        if (hb_ok) begin
            m_locked = 1; m_lock_at = ncyc;
            m_hops = hops; m_eth = e_threshold; m_recl = 0;
        end else if (data || expired) m_locked = 0;
        if (en && pkt_type == PKT_SOS) m_recl = 1;
        m_q = q_value_in;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all();
        chk("my_node_id", my_node_id, NID);
        chk("hops_from_sink", hops_from_sink, m_hops);
        chk("my_q_value", my_q_value, m_q);
        chk("e_thresh", e_thresh, m_eth);
        chk("my_timeslot", my_timeslot, m_ts);
        chk("role", {15'd0, role}, {15'd0, m_role == 2});
        chk("hb_locked", {15'd0, hb_locked}, {15'd0, m_locked});
        chk("low_e", {15'd0, low_e}, {15'd0, e_low});
        chk("recluster_req", {15'd0, recluster_req}, {15'd0, m_recl});
        chk("slot_fire", {15'd0, slot_fire}, {15'd0, e_fire});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1 check_all();
        @(negedge clk);
        en = 1'b0;
        q_value_in = W'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] d, input logic [15:0] a,
                        input logic [15:0] b);
        en = 1'b1; pkt_type = t; dest_id = d; hops = a; timeslot = a; e_threshold = b;
        step();
    endtask

    logic [2:0] types [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};

    initial begin
        nrst = 1'b0; en = 1'b0; pkt_type = '0; dest_id = '0; hops = '0; timeslot = '0;
        e_threshold = '0; energy = 16'd200; q_value_in = 16'h1234;

        idle(2);
        chk("rst_hops", hops_from_sink, 16'hFFFF);
        chk("rst_role", {15'd0, role}, 16'd0);
        chk("rst_slot_fire", {15'd0, slot_fire}, 16'd0);
        nrst = 1'b1;

        send(PKT_HB, 16'd0, 16'd3, 16'd100);
        chk("hb_hops", hops_from_sink, 16'd3);
        chk("hb_eth", e_thresh, 16'd100);
        chk("hb_lock", {15'd0, hb_locked}, 16'd1);
        send(PKT_HB, 16'd0, 16'd1, 16'd50);
        chk("hb_drop_hops", hops_from_sink, 16'd3);

        send(PKT_CHE, NID, 16'd0, 16'd0);
        chk("che_role", {15'd0, role}, 16'd1);
        send(PKT_CHE, 16'h0005, 16'd0, 16'd0);
        chk("che_other", {15'd0, role}, 16'd1);
        send(PKT_HB, 16'd0, 16'd7, 16'd100);
        chk("locked_hb_role", {15'd0, role}, 16'd1);
        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        chk("data_unlock", {15'd0, hb_locked}, 16'd0);
        send(PKT_HB, 16'd0, 16'd3, 16'd100);
        chk("hb_uncl", {15'd0, role}, 16'd0);

        send(PKT_TS, NID, 16'd5, 16'd0);
        chk("ts_value", my_timeslot, 16'd5);
        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("slot_pulse", {15'd0, slot_fire}, {15'd0, i == 6});
        end

        energy = 16'd90;
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("low_e_rise", {15'd0, low_e}, {15'd0, i >= 4});
        end
        energy = 16'd100;
        step();
        chk("low_e_clear", {15'd0, low_e}, 16'd0);

        send(PKT_SOS, 16'd0, 16'd0, 16'd0);
        chk("sos_set", {15'd0, recluster_req}, 16'd1);
        step();
        chk("sos_hold", {15'd0, recluster_req}, 16'd1);
        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        send(PKT_HB, 16'd0, 16'd3, 16'd100);
        chk("sos_clear", {15'd0, recluster_req}, 16'd0);

        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        send(PKT_HB, 16'd0, 16'd4, 16'd100);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("timeout_lock", {15'd0, hb_locked}, {15'd0, TO_EN ? (i < 8) : 1'b1});
        end
        send(PKT_HB, 16'd0, 16'd5, 16'd100);
        idle(7);
        send(PKT_HB, 16'd0, 16'd6, 16'd100);
        chk("expiry_hb_lock", {15'd0, hb_locked}, {15'd0, !TO_EN});
        chk("expiry_hb_hops", hops_from_sink, TO_EN ? 16'd5 : 16'd4);
        send(PKT_HB, 16'd0, 16'd9, 16'd100);
        chk("post_expiry_hb", hops_from_sink, TO_EN ? 16'd9 : 16'd4);

        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        send(PKT_HB, 16'd0, 16'd3, 16'd100);
        send(PKT_TS, NID, 16'd4, 16'd0);
        send(PKT_DATA, 16'd0, 16'd0, 16'd0);
        idle(2);
        nrst = 1'b0;
        step();
        chk("midrst_hops", hops_from_sink, 16'hFFFF);
        chk("midrst_ts", my_timeslot, 16'd0);
        nrst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_fire", {15'd0, slot_fire}, 16'd0);
        end

        for (int i = 0; i < 600; i++) begin
            nrst     = ($urandom_range(0, 99) != 0);
            en       = ($urandom_range(0, 1) == 1);
            pkt_type = types[$urandom_range(0, 6)];
            dest_id  = ($urandom_range(0, 2) != 0) ? NID : W'($urandom);
            hops     = W'($urandom);
            timeslot = W'($urandom_range(0, 6));
            e_threshold = ($urandom_range(0, 3) == 0) ? 16'd0 : W'($urandom_range(0, 300));
            if ($urandom_range(0, 4) == 0) energy = W'($urandom_range(0, 300));
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
